// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem
//   AHB-Lite responder backed by a single-port word memory. It sits behind one
//   hsel line of the address decoder. An accepted transfer either completes with
//   OKAY after WAIT_STATES wait cycles, or with a two-cycle ERROR response.
//
// Ports
//   hclk, hrst      clock, asynchronous active-high reset
//   hsel            slave select from the decoder
//   haddr           byte address (offset from BASE decodes the word)
//   htrans          00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//   hwrite, hsize   direction and log2(bytes) of the transfer
//   hwdata          write data, valid during the data phase
//   hready          bus-level ready (muxed hreadyout of the data-phase slave)
//   hreadyout       this slave's ready
//   hresp           0 OKAY, 1 ERROR
//   hrdata          read data, non-zero only in the final cycle of a read
//
// Handshake: an address phase is taken at a rising edge where
// hsel & hready & htrans[1] are all 1. The data phase that follows ends on the
// rising edge where hreadyout is 1. While hreadyout is 0, hready is low on the
// bus and nothing new is accepted.
module ahb_slave_mem #(
    parameter int              AW          = 32,
    parameter int              DW          = 32,
    parameter logic [AW-1:0]   BASE        = '0,
    parameter int              MEM_DEPTH   = 256,
    parameter int              WAIT_STATES = 0
) (
    input  logic          hclk,
    input  logic          hrst,
    input  logic          hsel,
    input  logic [AW-1:0] haddr,
    input  logic [1:0]    htrans,
    input  logic          hwrite,
    input  logic [2:0]    hsize,
    input  logic [DW-1:0] hwdata,
    input  logic          hready,
    output logic          hreadyout,
    output logic          hresp,
    output logic [DW-1:0] hrdata
);
    localparam int NB = DW / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t        state;
    logic [3:0]    wait_cnt;
    logic          r_write;
    logic [2:0]    r_size;
    logic [IW-1:0] r_idx;
    logic [LB-1:0] r_lane;

    logic [DW-1:0] mem [MEM_DEPTH];

    // Only htrans[1] distinguishes NONSEQ/SEQ from IDLE/BUSY.
    logic unused_htrans;
    assign unused_htrans = htrans[0];

    // Address-phase decode
    logic [AW-1:0] offset, word_off, align_mask;
    logic          size_err, align_err, range_err, xfer_err, open, launch;
    logic [IW-1:0] new_idx;
    logic [LB-1:0] new_lane;

    assign offset     = haddr - BASE;
    assign word_off   = offset >> LB;
    assign align_mask = (AW'(1) << hsize) - AW'(1);
    assign size_err   = hsize > 3'(LB);
    assign align_err  = |(haddr & align_mask);
    assign range_err  = (haddr < BASE) || (word_off >= AW'(MEM_DEPTH));
    assign xfer_err   = size_err | align_err | range_err;
    assign new_idx    = word_off[IW-1:0];
    assign new_lane   = offset[LB-1:0];

    // A new address phase can only be taken in the last cycle of a data phase
    // or when no data phase is in flight.
    assign open   = state inside {S_IDLE, S_DATA, S_ERR2};
    assign launch = open & hsel & hready & htrans[1];

    // Byte lanes of the registered transfer (little-endian).
    logic          wr_en;
    logic [NB-1:0] be;
    logic [DW-1:0] rd_launch;

    assign wr_en = (state == S_DATA) && r_write;

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            be[i] = (i >= int'(r_lane)) && (i < int'(r_lane) + (1 << r_size));
        end
    end

    // Zero-wait read launched in the same edge a write commits: forward the
    // written lanes so a back-to-back read sees the new data.
    always_comb begin
        rd_launch = mem[new_idx];
        if (wr_en && (new_idx == r_idx)) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) rd_launch[8*i +: 8] = hwdata[8*i +: 8];
            end
        end
    end

    // Memory is not reset. A reset during the data phase forces state to IDLE
    // asynchronously, so the pending write never sees wr_en.
    always_ff @(posedge hclk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[r_idx][8*i +: 8] <= hwdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            r_write   <= 1'b0;
            r_size    <= '0;
            r_idx     <= '0;
            r_lane    <= '0;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            hrdata    <= '0;
        end else if (launch) begin
            r_write <= hwrite;
            r_size  <= hsize;
            r_idx   <= new_idx;
            r_lane  <= new_lane;
            if (xfer_err) begin
                state     <= S_ERR1;
                hreadyout <= 1'b0;
                hresp     <= 1'b1;
                hrdata    <= '0;
            end else if (WAIT_STATES > 0) begin
                state     <= S_WAIT;
                wait_cnt  <= WS_LOAD;
                hreadyout <= 1'b0;
                hresp     <= 1'b0;
                hrdata    <= '0;
            end else begin
                state     <= S_DATA;
                hreadyout <= 1'b1;
                hresp     <= 1'b0;
                hrdata    <= hwrite ? '0 : rd_launch;
            end
        end else begin
            case (state)
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state     <= S_DATA;
                        hreadyout <= 1'b1;
                        hrdata    <= r_write ? '0 : mem[r_idx];
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_ERR1: begin
                    state     <= S_ERR2;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b1;
                end
                default: begin
                    // IDLE, or DATA/ERR2 ending with no new transfer.
                    state     <= S_IDLE;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b0;
                    hrdata    <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem
//   Two instances share the bus inputs: dut0 with no wait states at BASE 0,
//   dut1 with two wait states at BASE 0x400. dut_sel gates hsel so only one
//   instance sees transfers at a time; each instance's hready is its own
//   hreadyout. The driver pushes the expected response of every accepted
//   transfer into exp_q; a negedge monitor pops and checks each data phase.
module tb_ahb_slave_mem;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE0 = 32'h0;
    localparam logic [31:0] BASE1 = 32'h400;
    localparam int          WS0   = 0;
    localparam int          WS1   = 2;

    // Clock / reset
    logic hclk = 1'b0;
    logic hrst = 1'b0;
    always #5 hclk = ~hclk;

    logic        hsel, hwrite, dut_sel;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hsel0, hsel1, rdy0, rdy1, resp0, resp1;
    logic [31:0] rdata0, rdata1;
    logic        act_hsel, act_rdy, act_resp;
    logic [31:0] act_rdata;

    assign hsel0     = hsel & ~dut_sel;
    assign hsel1     = hsel & dut_sel;
    assign act_hsel  = dut_sel ? hsel1 : hsel0;
    assign act_rdy   = dut_sel ? rdy1 : rdy0;
    assign act_resp  = dut_sel ? resp1 : resp0;
    assign act_rdata = dut_sel ? rdata1 : rdata0;

    ahb_slave_mem #(.AW(32), .DW(32), .BASE(BASE0), .MEM_DEPTH(DEPTH), .WAIT_STATES(WS0)) dut0 (
        .hclk(hclk), .hrst(hrst), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(rdy0),
        .hreadyout(rdy0), .hresp(resp0), .hrdata(rdata0));

    ahb_slave_mem #(.AW(32), .DW(32), .BASE(BASE1), .MEM_DEPTH(DEPTH), .WAIT_STATES(WS1)) dut1 (
        .hclk(hclk), .hrst(hrst), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(rdy1),
        .hreadyout(rdy1), .hresp(resp1), .hrdata(rdata1));

    // Scoreboard state: {error, rdata}
    logic [32:0] exp_q[$];
    logic [31:0] mdl [2][DEPTH];
    int          total = 0;
    int          bad   = 0;
    bit          in_dp = 0;
    bit          start_dp = 0;
    logic [32:0] cur;
    int          k;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s @%0t: got no completion expected completion", name, $time);
    endtask

    // Monitor
    always @(negedge hclk) begin
        logic        e_rdy, e_resp;
        logic [31:0] e_rdata;
        int          ws;
        if (hrst) begin
            in_dp    = 0;
            start_dp = 0;
        end else begin
            if (start_dp) begin
                start_dp = 0;
                if (exp_q.size() == 0) note_fail("queue_empty");
                else begin
                    cur   = exp_q.pop_front();
                    in_dp = 1;
                    k     = 0;
                end
            end
            if (in_dp) begin
                ws = dut_sel ? WS1 : WS0;
                if (cur[32]) begin
                    e_resp  = 1'b1;
                    e_rdy   = (k >= 1);
                    e_rdata = '0;
                end else begin
                    e_resp  = 1'b0;
                    e_rdy   = (k >= ws);
                    e_rdata = e_rdy ? cur[31:0] : 32'h0;
                end
                check("dp_ready", 32'(act_rdy), 32'(e_rdy));
                check("dp_resp", 32'(act_resp), 32'(e_resp));
                check("dp_rdata", act_rdata, e_rdata);
                if (act_rdy) in_dp = 0;
                else begin
                    k++;
                    if (k > 40) begin
                        note_fail("dp_timeout");
                        in_dp = 0;
                    end
                end
            end else begin
                check("idle_ready", 32'(act_rdy), 32'd1);
                check("idle_resp", 32'(act_resp), 32'd0);
                check("idle_rdata", act_rdata, 32'h0);
            end
            start_dp = act_hsel & act_rdy & htrans[1];
        end
    end

    // Driver tasks
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata);
        bit          got, err;
        int          guard;
        int unsigned nbytes, lane, word;
        logic [31:0] base;
        logic [63:0] mask;
        hsel = 1'b1; haddr = addr; htrans = 2'b10; hwrite = wr; hsize = size;
        got = 0; guard = 0;
        forever begin
            @(negedge hclk);
            got = act_rdy;
            @(posedge hclk);
            if (got) break;
            guard++;
            if (guard > 50) break;
        end
        #1;
        hwdata = wdata; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
        if (!got) begin
            note_fail("accept_timeout");
            return;
        end
        base   = dut_sel ? BASE1 : BASE0;
        nbytes = 1 << size;
        err    = (size > 3'd2) || ((addr % nbytes) != 0) || (addr < base) ||
                 (((addr - base) / 4) >= DEPTH);
        if (err) exp_q.push_back({1'b1, 32'h0});
        else begin
            word = (addr - base) / 4;
            if (wr) begin
                lane = addr % 4;
                mask = ((64'd1 << (8 * nbytes)) - 64'd1) << (8 * lane);
                mdl[dut_sel][word] = (mdl[dut_sel][word] & ~mask[31:0]) | (wdata & mask[31:0]);
                exp_q.push_back({1'b0, 32'h0});
            end else begin
                exp_q.push_back({1'b0, mdl[dut_sel][word]});
            end
        end
    endtask

    task automatic idle_cycle(input bit sel, input logic [1:0] tr, input bit wr, input logic [31:0] addr);
        hsel = sel; htrans = tr; hwrite = wr; haddr = addr; hsize = 3'd2;
        @(posedge hclk);
        #1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || in_dp || start_dp) && g < 200) begin
            @(posedge hclk);
            g++;
        end
        if (g >= 200) note_fail("drain_timeout");
        @(posedge hclk);
        #1;
    endtask

    task automatic directed(input logic [31:0] base);
        xfer(1, base + 32'h10, 3'd2, 32'hDEADBEEF);
        xfer(0, base + 32'h10, 3'd2, 32'h0);
        xfer(1, base + 32'h10, 3'd2, 32'h11223344);
        xfer(1, base + 32'h13, 3'd0, 32'hAA000000);
        xfer(0, base + 32'h10, 3'd2, 32'h0);
        xfer(1, base + 32'h10, 3'd1, 32'h00005566);
        xfer(0, base + 32'h10, 3'd2, 32'h0);
        xfer(0, base, 3'd2, 32'h0);
        xfer(0, base + 32'(DEPTH * 4), 3'd2, 32'h0);
        xfer(0, base + 32'h1, 3'd1, 32'h0);
        xfer(1, base + 32'h1, 3'd1, 32'hFFFFFFFF);
        xfer(0, base, 3'd2, 32'h0);
        xfer(0, base + 32'h2, 3'd2, 32'h0);
        xfer(0, base, 3'd3, 32'h0);
        xfer(0, base + 32'(DEPTH * 4 - 4), 3'd2, 32'h0);
        idle_cycle(1, 2'b00, 1, base + 32'h20);
        idle_cycle(0, 2'b10, 1, base + 32'h20);
        idle_cycle(1, 2'b01, 1, base + 32'h20);
        xfer(0, base + 32'h20, 3'd2, 32'h0);
        if (base >= 4) xfer(0, base - 32'h4, 3'd2, 32'h0);
        drain();
    endtask

    task automatic rand_run(input int n);
        logic [31:0] base, addr;
        logic [2:0]  size;
        int          kind, word;
        base = dut_sel ? BASE1 : BASE0;
        for (int i = 0; i < n; i++) begin
            size = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            word = $urandom_range(0, DEPTH - 1);
            kind = $urandom_range(0, 11);
            addr = base + 32'(word * 4) + 32'($urandom_range(0, 3) & ~((1 << size) - 1) & 3);
            if (kind == 0) addr = base + 32'(DEPTH * 4) + 32'($urandom_range(0, 15) * 4);
            else if (kind == 1) addr = (base >= 4) ? base - 32'($urandom_range(1, 4) * 4) : 32'(DEPTH * 4);
            else if (kind == 2) addr = base + 32'(word * 4) + 32'($urandom_range(1, 3));
            xfer(bit'($urandom_range(0, 1)), addr, size, $urandom);
            if ($urandom_range(0, 4) == 0)
                idle_cycle(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 1)), 1, addr);
        end
        drain();
    endtask

    task automatic reset_mid_write(input logic [31:0] addr);
        xfer(1, addr, 3'd2, 32'h0BAD1DEA);
        drain();
        hsel = 1'b1; haddr = addr; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        @(posedge hclk);
        #1;
        hwdata = 32'hCAFEF00D; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
        check("wait_before_rst", 32'(act_rdy), 32'd0);
        #1 hrst = 1'b1;
        #1;
        check("rst_async_ready", 32'(act_rdy), 32'd1);
        check("rst_async_resp", 32'(act_resp), 32'd0);
        @(posedge hclk);
        #2 hrst = 1'b0;
        xfer(0, addr, 3'd2, 32'h0);
        drain();
    endtask

    initial begin
        hsel = 1'b0; hwrite = 1'b0; haddr = '0; hwdata = '0; htrans = 2'b00; hsize = 3'd2;
        dut_sel = 1'b0;
        #1 hrst = 1'b1;
        #2;
        check("rst_ready0", 32'(rdy0), 32'd1);
        check("rst_resp0", 32'(resp0), 32'd0);
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_ready1", 32'(rdy1), 32'd1);
        check("rst_resp1", 32'(resp1), 32'd0);
        check("rst_rdata1", rdata1, 32'h0);
        repeat (2) @(posedge hclk);
        #1 hrst = 1'b0;

        for (int d = 0; d < 2; d++) begin
            dut_sel = d[0];
            for (int w = 0; w < DEPTH; w++)
                xfer(1, (d == 0 ? BASE0 : BASE1) + 32'(w * 4), 3'd2, $urandom);
            drain();
            directed(d == 0 ? BASE0 : BASE1);
            rand_run(200);
        end
        dut_sel = 1'b1;
        reset_mid_write(BASE1 + 32'h40);
        dut_sel = 1'b0;
        repeat (3) @(posedge hclk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog @%0t: got no end expected finish", $time);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
